oqpsk_tx_framer: RTL

Frame builder upstream of the OQPSK raised-cosine transmitter. Accepts a payload length and a byte stream over a valid/ready handshake. Emits an IEEE 802.15.4-style serial frame (preamble, SFD, length byte, payload, all LSB-first) on a single bit line, advancing one bit per 2 MHz bit strobe. `BIT_OUT` drives the modulator's `BitIn`, `BIT_EN` comes from the modulator's 2 MHz enable, and `TX_EN` gates the modulator's counters.

---
 rtl/oqpsk_tx_pkg.sv | 18 +
 rtl/tx_byte_hold.sv | 52 +++++
 rtl/oqpsk_tx_framer.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/oqpsk_tx_pkg.sv
// Shared definitions for the OQPSK transmit framer: frame section states
// and the default header constants.
package oqpsk_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PRE  = 3'd1,
    ST_SFD  = 3'd2,
    ST_PHR  = 3'd3,
    ST_PAY  = 3'd4
  } state_e;

  localparam logic [7:0] SFD_DEFAULT     = 8'hA7;
  localparam int         MAX_LEN_DEFAULT = 127;
  localparam int         PHR_W           = 8;
  localparam int         LEN_W           = 7;

endpackage

// File: rtl/tx_byte_hold.sv
// One-entry payload holding register. The upstream side pushes through a
// valid/ready handshake and the framer pops when a payload byte starts.
// A push and a pop in the same cycle hand the old byte to the popper while
// the new byte takes its place. Clear drops any held byte on frame abort.
module tx_byte_hold (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       clear_i,
  input  logic       push_i,
  input  logic [7:0] data_i,
  input  logic       pop_i,
  output logic [7:0] data_o,
  output logic       full_o,
  output logic       full_next_o
);

  logic [7:0] data_q, data_d;
  logic       full_q, full_d;

  // Next occupancy and contents: clear wins, then a push refills after a pop
  always_comb begin
    full_d = full_q;
    data_d = data_q;
    if (clear_i) begin
      full_d = 1'b0;
    end else begin
      if (pop_i) begin
        full_d = 1'b0;
      end
      if (push_i) begin
        full_d = 1'b1;
        data_d = data_i;
      end
    end
  end

  // Holding register storage
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      full_q <= 1'b0;
      data_q <= 8'h00;
    end else begin
      full_q <= full_d;
      data_q <= data_d;
    end
  end

  assign data_o      = data_q;
  assign full_o      = full_q;
  assign full_next_o = full_d;

endmodule

// File: rtl/oqpsk_tx_framer.sv
// Frame builder ahead of the OQPSK modulator: preamble, SFD, length byte
// and payload, all LSB-first, one bit per bit strobe. A new byte is chosen
// on the first strobe of each byte slot, so a payload byte only has to be
// held by the edge of the last strobe of the byte before it.
// PREAMBLE_BYTES is expected to be at least 1.
module oqpsk_tx_framer
  import oqpsk_tx_pkg::*;
#(
  parameter int         PREAMBLE_BYTES = 4,
  parameter logic [7:0] SFD            = SFD_DEFAULT,
  parameter int         MAX_LEN        = MAX_LEN_DEFAULT
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             bit_en_i,
  input  logic             start_i,
  input  logic [LEN_W-1:0] len_i,
  input  logic [7:0]       data_in_i,
  input  logic             data_valid_i,
  output logic             data_ready_o,
  output logic             bit_out_o,
  output logic             tx_en_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o
);

  localparam logic [7:0]       PRE_CNT   = 8'(PREAMBLE_BYTES);
  localparam logic [LEN_W-1:0] MAX_LEN_V = LEN_W'(MAX_LEN);

  state_e           state_q, state_d;
  logic [7:0]       shift_q, shift_d;
  logic [2:0]       bitCnt_q, bitCnt_d;
  logic [7:0]       byteCnt_q, byteCnt_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] acceptCnt_q, acceptCnt_d;
  logic             bitOut_q, bitOut_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             dataReady_q, dataReady_d;

  logic             holdPush, holdPop, holdClear;
  logic [7:0]       holdData;
  logic             holdFull, holdFullNext;
  logic [7:0]       byteSel;
  logic             emitByte;
  logic             lenOk;

  assign holdPush = data_valid_i && dataReady_q;
  assign lenOk    = (len_i != '0) && (len_i <= MAX_LEN_V);

  tx_byte_hold u_hold (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .clear_i     (holdClear),
    .push_i      (holdPush),
    .data_i      (data_in_i),
    .pop_i       (holdPop),
    .data_o      (holdData),
    .full_o      (holdFull),
    .full_next_o (holdFullNext)
  );

  // Frame sequencing: byte selection on slot start, shifting, section changes
  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    bitCnt_d    = bitCnt_q;
    byteCnt_d   = byteCnt_q;
    len_d       = len_q;
    acceptCnt_d = acceptCnt_q;
    bitOut_d    = bitOut_q;
    done_d      = 1'b0;
    err_d       = 1'b0;
    holdPop     = 1'b0;
    holdClear   = 1'b0;
    byteSel     = 8'h00;
    emitByte    = 1'b0;

    if (holdPush) begin
      acceptCnt_d = acceptCnt_q + 1'b1;
    end

    if (state_q == ST_IDLE) begin
      if (start_i) begin
        if (lenOk) begin
          state_d     = ST_PRE;
          len_d       = len_i;
          shift_d     = 8'h00;
          bitCnt_d    = 3'd0;
          byteCnt_d   = 8'd0;
          acceptCnt_d = '0;
        end else begin
          err_d = 1'b1;
        end
      end
    end else if (bit_en_i) begin
      if (bitCnt_q == 3'd0) begin
        case (state_q)
          ST_PRE: begin
            byteSel   = 8'h00;
            byteCnt_d = byteCnt_q + 8'd1;
            emitByte  = 1'b1;
          end
          ST_SFD: begin
            byteSel  = SFD;
            emitByte = 1'b1;
          end
          ST_PHR: begin
            byteSel  = {{(PHR_W-LEN_W){1'b0}}, len_q};
            emitByte = 1'b1;
          end
          ST_PAY: begin
            if (byteCnt_q == {1'b0, len_q}) begin
              done_d    = 1'b1;
              bitOut_d  = 1'b0;
              state_d   = ST_IDLE;
              holdClear = 1'b1;
            end else if (holdFull) begin
              byteSel   = holdData;
              holdPop   = 1'b1;
              byteCnt_d = byteCnt_q + 8'd1;
              emitByte  = 1'b1;
            end else begin
              err_d     = 1'b1;
              bitOut_d  = 1'b0;
              state_d   = ST_IDLE;
              holdClear = 1'b1;
            end
          end
          default: ;
        endcase
      end else begin
        bitOut_d = shift_q[0];
        shift_d  = {1'b0, shift_q[7:1]};
        bitCnt_d = bitCnt_q + 3'd1;
        if (bitCnt_q == 3'd7) begin
          case (state_q)
            ST_PRE: begin
              if (byteCnt_q == PRE_CNT) begin
                state_d   = ST_SFD;
                byteCnt_d = 8'd0;
              end
            end
            ST_SFD: state_d = ST_PHR;
            ST_PHR: begin
              state_d   = ST_PAY;
              byteCnt_d = 8'd0;
            end
            default: ;
          endcase
        end
      end
    end

    if (emitByte) begin
      bitOut_d = byteSel[0];
      shift_d  = {1'b0, byteSel[7:1]};
      bitCnt_d = 3'd1;
    end
  end

  assign dataReady_d = !holdFullNext && (acceptCnt_d < len_d) && (state_d != ST_IDLE);

  // State, datapath and registered output flags
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      shift_q     <= 8'h00;
      bitCnt_q    <= 3'd0;
      byteCnt_q   <= 8'd0;
      len_q       <= '0;
      acceptCnt_q <= '0;
      bitOut_q    <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      dataReady_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      bitCnt_q    <= bitCnt_d;
      byteCnt_q   <= byteCnt_d;
      len_q       <= len_d;
      acceptCnt_q <= acceptCnt_d;
      bitOut_q    <= bitOut_d;
      done_q      <= done_d;
      err_q       <= err_d;
      dataReady_q <= dataReady_d;
    end
  end

  assign data_ready_o = dataReady_q;
  assign bit_out_o    = bitOut_q;
  assign busy_o       = (state_q != ST_IDLE);
  assign tx_en_o      = (state_q != ST_IDLE);
  assign done_o       = done_q;
  assign err_o        = err_q;

endmodule
